host_mmio_ctrl: RTL and testbench

Synthesizable host-interface peripheral on the core's OBI-style data bus. Replaces the bench-side snooping of tohost/putchar_stdout and the fixed periodic interrupt pulse with memory-mapped registers:
- exit-code register;
- buffered STDOUT byte FIFO with drain port;
- NUM_TIMERS programmable interrupt timers with pending/W1C semantics.

Sits beside sim_memory on the data bus; irq_o feeds the core's irq_i lines.

---
 rtl/host_mmio_ctrl_if.sv | 33 +++
 rtl/host_mmio_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_host_mmio_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/host_mmio_ctrl_if.sv
// ---------------------------------------------------------------------------
// host_mmio_ctrl_if
// OBI-style data-bus bundle between the core (master) and host_mmio_ctrl
// (slave).
//   req    : master -> slave, bus request
//   we     : master -> slave, write enable
//   be     : master -> slave, byte enables
//   addr   : master -> slave, byte address
//   wdata  : master -> slave, write data
//   gnt    : slave -> master, grant (combinational on the request)
//   rvalid : slave -> master, response valid, one cycle after each grant
//   rdata  : slave -> master, read data, valid with rvalid
// ---------------------------------------------------------------------------
interface host_mmio_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/host_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// host_mmio_ctrl
// Host-interface peripheral on the core's data bus. Provides:
//   - an exit-code register (first full-word write wins, sticky valid),
//   - a buffered STDOUT byte FIFO with a valid/ready drain port,
//   - NUM_TIMERS programmable interrupt timers with W1C pending bits.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   bus           host_mmio_ctrl_if.slave (req/we/be/addr/wdata -> gnt/rvalid/rdata)
//   char_valid_o  FIFO head valid
//   char_o        FIFO head byte (0 when empty)
//   char_ready_i  consumer pops the head when valid & ready
//   exit_valid_o  sticky: exit code captured
//   exit_code_o   captured exit code
//   irq_o         interrupt lines; bit IRQ_LSB+k = pending[k], others 0
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 TOHOST   0x04 STDOUT   0x08 STATUS   0x0C PENDING (W1C)
//   0x20+8k PERIOD_k   0x24+8k CTRL_k {auto_reload, enable}
//
// Optional build macro: HOST_MMIO_CYCLE_CNT_EN adds a 64-bit free-running
// cycle counter readable at 0x10 (low, snapshots high) and 0x14 (high
// snapshot). Without it those offsets read 0.
// ---------------------------------------------------------------------------
module host_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned IRQ_LSB    = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    host_mmio_ctrl_if.slave         bus,
    output logic                    char_valid_o,
    output logic [7:0]              char_o,
    input  logic                    char_ready_i,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_code_o,
    output logic [31:0]             irq_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [7:0] OFF_TOHOST  = 8'h00;
    localparam logic [7:0] OFF_STDOUT  = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_PENDING = 8'h0C;
    localparam logic [7:0] OFF_CYC_LO  = 8'h10;
    localparam logic [7:0] OFF_CYC_HI  = 8'h14;

    // -----------------------------------------------------------------------
    // Address decode and grant
    // -----------------------------------------------------------------------
    logic       sel;
    logic [7:0] off;
    logic       fifo_full;
    logic       stdout_blocked;
    logic       wr_en;
    logic       rd_en;

    assign sel = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign off = bus.addr[7:0];

    // A STDOUT write against a full FIFO is held off rather than dropped.
    assign stdout_blocked = bus.we && (off == OFF_STDOUT) && fifo_full;

    // NOTE: gnt is combinational, so it is gated with rst_i explicitly;
    // registered outputs get their reset value from the async reset branch.
    assign bus.gnt = !rst_i && bus.req && sel && !stdout_blocked;

    assign wr_en = bus.gnt && bus.we;
    assign rd_en = bus.gnt && !bus.we;

    // Per-timer register hits, decoded once and shared by write and read paths.
    logic [NUM_TIMERS-1:0] period_hit;
    logic [NUM_TIMERS-1:0] ctrl_hit;

    always_comb begin
        period_hit = '0;
        ctrl_hit   = '0;
        for (int k = 0; k < int'(NUM_TIMERS); k++) begin
            period_hit[k] = (off == 8'(32'h20 + 8 * k));
            ctrl_hit[k]   = (off == 8'(32'h24 + 8 * k));
        end
    end

    // -----------------------------------------------------------------------
    // Exit-code register: first full-word write wins
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exit_valid_o <= 1'b0;
            exit_code_o  <= '0;
        end else if (wr_en && (off == OFF_TOHOST) && (bus.be == 4'hF) && !exit_valid_o) begin
            exit_valid_o <= 1'b1;
            exit_code_o  <= bus.wdata;
        end
    end

    // -----------------------------------------------------------------------
    // STDOUT FIFO
    // -----------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push;
    logic             pop;

    assign push         = wr_en && (off == OFF_STDOUT) && bus.be[0];
    assign char_valid_o = (level != '0);
    assign pop          = char_valid_o && char_ready_i;
    assign fifo_full    = (level == LVL_W'(FIFO_DEPTH));
    assign char_o       = char_valid_o ? fifo_mem[rd_ptr] : 8'h00;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // NOTE: the storage array has no reset; an empty level makes stale
    // entries unobservable, and char_o is forced to 0 while empty.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    // -----------------------------------------------------------------------
    // Timers
    // -----------------------------------------------------------------------
    logic [31:0]           period [NUM_TIMERS];
    logic [31:0]           count  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] enable;
    logic [NUM_TIMERS-1:0] auto_reload;
    logic [NUM_TIMERS-1:0] pending;
    logic [NUM_TIMERS-1:0] fire;
    logic [NUM_TIMERS-1:0] pend_clr;

    // A count already past a shortened period keeps counting and only fires
    // after wrapping through 2^32-1, so an equality compare is sufficient.
    always_comb begin
        fire = '0;
        for (int k = 0; k < int'(NUM_TIMERS); k++) begin
            fire[k] = enable[k] && (period[k] != 32'd0) && (count[k] == period[k] - 32'd1);
        end
    end

    assign pend_clr = (wr_en && (off == OFF_PENDING) && bus.be[0])
                      ? bus.wdata[NUM_TIMERS-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable      <= '0;
            auto_reload <= '0;
            pending     <= '0;
            for (int k = 0; k < int'(NUM_TIMERS); k++) begin
                period[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            // Set wins over a same-cycle W1C.
            pending <= (pending & ~pend_clr) | fire;
            for (int k = 0; k < int'(NUM_TIMERS); k++) begin
                if (wr_en && period_hit[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.be[b]) period[k][8*b +: 8] <= bus.wdata[8*b +: 8];
                    end
                end

                if (wr_en && ctrl_hit[k] && bus.be[0]) begin
                    enable[k]      <= bus.wdata[0];
                    auto_reload[k] <= bus.wdata[1];
                    if (bus.wdata[0]) count[k] <= '0;
                end else if (fire[k]) begin
                    count[k] <= '0;
                    if (!auto_reload[k]) enable[k] <= 1'b0;
                end else if (enable[k] && (period[k] != 32'd0)) begin
                    count[k] <= count[k] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        irq_o = '0;
        for (int k = 0; k < int'(NUM_TIMERS); k++) begin
            irq_o[IRQ_LSB + k] = pending[k];
        end
    end

    // -----------------------------------------------------------------------
    // Optional cycle counter
    // -----------------------------------------------------------------------
`ifdef HOST_MMIO_CYCLE_CNT_EN
    logic [63:0] cycle_cnt;
    logic [31:0] cyc_hi_snap;

    // Reading the low word freezes the high word so a following high-word
    // read forms a coherent 64-bit value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt   <= '0;
            cyc_hi_snap <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (rd_en && (off == OFF_CYC_LO)) cyc_hi_snap <= cycle_cnt[63:32];
        end
    end
`else
    // No counter in this build; its offsets fall through to read-as-zero.
`endif

    // -----------------------------------------------------------------------
    // Read mux and response register
    // -----------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_TOHOST:  rd_mux = exit_code_o;
            OFF_STATUS:  rd_mux = {14'd0, exit_valid_o, fifo_full, 16'(level)};
            OFF_PENDING: rd_mux = 32'(pending);
`ifdef HOST_MMIO_CYCLE_CNT_EN
            OFF_CYC_LO:  rd_mux = cycle_cnt[31:0];
            OFF_CYC_HI:  rd_mux = cyc_hi_snap;
`else
            OFF_CYC_LO, OFF_CYC_HI: rd_mux = '0;
`endif
            default:     rd_mux = '0;
        endcase
        for (int k = 0; k < int'(NUM_TIMERS); k++) begin
            if (period_hit[k]) rd_mux = period[k];
            if (ctrl_hit[k])   rd_mux = {30'd0, auto_reload[k], enable[k]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.gnt;
            bus.rdata  <= rd_en ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_host_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_host_mmio_ctrl
// Directed bench for host_mmio_ctrl (FIFO_DEPTH = 4, NUM_TIMERS = 2,
// IRQ_LSB = 11). Inputs change on the falling edge; outputs are sampled
// 1 ns after an edge.
// ---------------------------------------------------------------------------
module tb_host_mmio_ctrl;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        char_ready_i;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;
    logic [31:0] irq_o;

    int checks   = 0;
    int failures = 0;

    host_mmio_ctrl_if bus();

    host_mmio_ctrl #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .NUM_TIMERS (2),
        .IRQ_LSB    (11)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .char_ready_i (char_ready_i),
        .exit_valid_o (exit_valid_o),
        .exit_code_o  (exit_code_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transfer; waits a bounded number of cycles for the grant and
    // returns the response sampled just after the grant edge.
    task automatic xfer(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic rv, output logic ok);
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = w; bus.be = b; bus.addr = a; bus.wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.gnt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;
        rv = bus.rvalid;
        rd = bus.rdata;
    endtask

    task automatic wr(input string tag, input logic [7:0] o, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] rd;
        logic rv, ok;
        xfer(1'b1, b, BASE + 32'(o), d, rd, rv, ok);
        chk({tag, ".gnt"}, 32'(ok), 32'd1);
        chk({tag, ".rvalid"}, 32'(rv), 32'd1);
        chk({tag, ".rdata"}, rd, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] o, input logic [31:0] exp);
        logic [31:0] rd;
        logic rv, ok;
        xfer(1'b0, 4'hF, BASE + 32'(o), 32'd0, rd, rv, ok);
        chk({tag, ".gnt"}, 32'(ok), 32'd1);
        chk({tag, ".rvalid"}, 32'(rv), 32'd1);
        chk(tag, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] msg [5];
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h44; msg[4] = 8'h45;

        rst_i = 1'b1;
        char_ready_i = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;

        // ---- reset state ----
        #12;
        chk("rst.rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst.rdata", bus.rdata, 32'd0);
        chk("rst.char_valid", 32'(char_valid_o), 32'd0);
        chk("rst.char", 32'(char_o), 32'd0);
        chk("rst.exit_valid", 32'(exit_valid_o), 32'd0);
        chk("rst.exit_code", exit_code_o, 32'd0);
        chk("rst.irq", irq_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_chk("status.idle", 8'h08, 32'h0000_0000);

        // ---- TOHOST ----
        wr("tohost.partial", 8'h00, 32'h0000_0007, 4'h3);
        chk("tohost.partial.valid", 32'(exit_valid_o), 32'd0);
        wr("tohost.first", 8'h00, 32'h0000_0000, 4'hF);
        chk("tohost.first.valid", 32'(exit_valid_o), 32'd1);
        chk("tohost.first.code", exit_code_o, 32'd0);
        wr("tohost.second", 8'h00, 32'h0000_0005, 4'hF);
        chk("tohost.second.code", exit_code_o, 32'd0);
        rd_chk("tohost.read", 8'h00, 32'd0);
        rd_chk("status.exit", 8'h08, 32'h0002_0000);

        // ---- STDOUT backpressure ----
        wr("stdout.nobe0", 8'h04, 32'h0000_0058, 4'hE);
        chk("stdout.nobe0.valid", 32'(char_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) wr("stdout.push", 8'h04, 32'(msg[i]), 4'h1);
        chk("stdout.head", 32'(char_o), 32'h41);
        rd_chk("status.full", 8'h08, 32'h0003_0004);

        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b1; bus.be = 4'h1; bus.addr = BASE + 32'h04; bus.wdata = 32'(msg[4]);
        #1 chk("stdout.full.gnt0", 32'(bus.gnt), 32'd0);
        @(negedge clk_i);
        #1 chk("stdout.full.gnt1", 32'(bus.gnt), 32'd0);
        char_ready_i = 1'b1;
        chk("drain.0", 32'(char_o), 32'(msg[0]));
        chk("stdout.ready.gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk_i);
        #1 chk("stdout.after_pop.gnt", 32'(bus.gnt), 32'd1);
        chk("drain.1", 32'(char_o), 32'(msg[1]));
        @(posedge clk_i);
        #1;
        bus.req = 1'b0; bus.we = 1'b0;
        chk("stdout.e.rvalid", 32'(bus.rvalid), 32'd1);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk_i);
            #1 chk("drain.n", 32'(char_o), 32'(msg[i]));
        end
        @(negedge clk_i);
        #1 chk("drain.empty", 32'(char_valid_o), 32'd0);
        char_ready_i = 1'b0;

        // ---- auto-reload timer 0 ----
        wr("t0.period", 8'h20, 32'd10, 4'hF);
        wr("t0.ctrl", 8'h24, 32'd3, 4'hF);
        chk("t0.irq.start", irq_o, 32'd0);
        repeat (9) @(posedge clk_i);
        #1 chk("t0.irq.c9", irq_o, 32'd0);
        @(posedge clk_i);
        #1 chk("t0.irq.c10", irq_o, 32'h0000_0800);
        wr("t0.w1c", 8'h0C, 32'h1, 4'hF);
        chk("t0.irq.cleared", irq_o, 32'd0);
        repeat (8) @(posedge clk_i);
        #1 chk("t0.irq.c19", irq_o, 32'd0);
        @(posedge clk_i);
        #1 chk("t0.irq.c20", irq_o, 32'h0000_0800);
        wr("t0.stop", 8'h24, 32'd0, 4'hF);
        wr("t0.w1c2", 8'h0C, 32'h1, 4'hF);
        chk("t0.irq.off", irq_o, 32'd0);

        // ---- one-shot timer 1 with W1C collision ----
        wr("t1.period", 8'h28, 32'd5, 4'hF);
        wr("t1.ctrl", 8'h2C, 32'd1, 4'hF);
        repeat (4) @(posedge clk_i);
        #1 chk("t1.irq.c4", irq_o, 32'd0);
        wr("t1.w1c.collide", 8'h0C, 32'h2, 4'hF);
        chk("t1.irq.setwins", irq_o, 32'h0000_1000);
        rd_chk("t1.ctrl.read", 8'h2C, 32'd0);
        rd_chk("pending.read", 8'h0C, 32'h2);
        wr("t1.w1c", 8'h0C, 32'h2, 4'hF);
        chk("t1.irq.cleared", irq_o, 32'd0);

        // ---- bus timing ----
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = BASE + 32'h20;
        #1 chk("b2b.gnt0", 32'(bus.gnt), 32'd1);
        @(posedge clk_i);
        #1;
        bus.addr = BASE + 32'h3C;
        chk("b2b.rvalid0", 32'(bus.rvalid), 32'd1);
        chk("b2b.rdata0", bus.rdata, 32'd10);
        chk("b2b.gnt1", 32'(bus.gnt), 32'd1);
        @(posedge clk_i);
        #1;
        bus.req = 1'b0;
        chk("b2b.rvalid1", 32'(bus.rvalid), 32'd1);
        chk("b2b.rdata1", bus.rdata, 32'd0);
        @(posedge clk_i);
        #1 chk("b2b.rvalid.idle", 32'(bus.rvalid), 32'd0);
        @(negedge clk_i);
        bus.req = 1'b1; bus.addr = BASE + 32'h100;
        #1 chk("unsel.gnt", 32'(bus.gnt), 32'd0);
        @(posedge clk_i);
        #1 chk("unsel.rvalid", 32'(bus.rvalid), 32'd0);
        bus.req = 1'b0; bus.addr = '0;

`ifndef HOST_MMIO_CYCLE_CNT_EN
        rd_chk("cyc.lo.absent", 8'h10, 32'd0);
        rd_chk("cyc.hi.absent", 8'h14, 32'd0);
`else
        rd_chk("cyc.hi.snap", 8'h14, 32'd0);
`endif

        // ---- async reset mid-burst ----
        wr("rst.t0.period", 8'h20, 32'd100, 4'hF);
        wr("rst.t0.ctrl", 8'h24, 32'd1, 4'hF);
        for (int i = 0; i < 3; i++) wr("rst.push", 8'h04, 32'(msg[i]), 4'h1);
        rd_chk("rst.status.pre", 8'h08, 32'h0002_0003);
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = BASE + 32'h08;
        @(posedge clk_i);
        #1;
        chk("arst.pre.rvalid", 32'(bus.rvalid), 32'd1);
        chk("arst.pre.char_valid", 32'(char_valid_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("arst.gnt", 32'(bus.gnt), 32'd0);
        chk("arst.rvalid", 32'(bus.rvalid), 32'd0);
        chk("arst.rdata", bus.rdata, 32'd0);
        chk("arst.char_valid", 32'(char_valid_o), 32'd0);
        chk("arst.char", 32'(char_o), 32'd0);
        chk("arst.exit_valid", 32'(exit_valid_o), 32'd0);
        chk("arst.exit_code", exit_code_o, 32'd0);
        chk("arst.irq", irq_o, 32'd0);
        bus.req = 1'b0; bus.addr = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_chk("arst.status", 8'h08, 32'd0);
        rd_chk("arst.ctrl0", 8'h24, 32'd0);
        rd_chk("arst.period0", 8'h20, 32'd0);
        repeat (10) @(posedge clk_i);
        #1 chk("arst.irq.quiet", irq_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
